// File: rtl/line_window_gen.sv
// Turns a raster pixel stream into packed 3-row columns {row-2, row-1, row} for a 3x3 window.
// Optional border replication for rows 0 and 1 is enabled by defining LWG_BORDER_REPLICATE_EN.
module line_window_gen #(
  parameter int PIXEL_WIDTH  = 14,
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic [PIXEL_WIDTH-1:0]   pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [3*PIXEL_WIDTH-1:0] col_data,
  output logic                     col_valid,
  output logic                     col_last,
  output logic                     frame_done
);

  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HEIGHT - 1);

  generate
    if (IMAGE_WIDTH < 2 || IMAGE_HEIGHT < 3) begin : g_bad_params
      $error("line_window_gen needs IMAGE_WIDTH >= 2 and IMAGE_HEIGHT >= 3");
    end
  endgenerate

  logic [PIXEL_WIDTH-1:0] line1 [IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] line2 [IMAGE_WIDTH];

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic [CW-1:0]            col_p0;
  logic [RW-1:0]            row_p0;
  logic [PIXEL_WIDTH-1:0]   rd1_p0;
  logic [PIXEL_WIDTH-1:0]   rd2_p0;
  logic                     end_col_p0;
  logic                     end_row_p0;
  logic                     win_vld_p0;
  logic [3*PIXEL_WIDTH-1:0] win_data_p0;

  logic [3*PIXEL_WIDTH-1:0] data_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic                     done_p1;

  // Stage p0: position of the incoming pixel and line-store reads
  always_comb begin
    col_p0      = sof ? '0 : col_cnt;
    row_p0      = sof ? '0 : row_cnt;
    rd1_p0      = line1[col_p0];
    rd2_p0      = line2[col_p0];
    end_col_p0  = (col_p0 == COL_MAX);
    end_row_p0  = (row_p0 == ROW_MAX);
    win_data_p0 = {rd2_p0, rd1_p0, pix_in};
`ifdef LWG_BORDER_REPLICATE_EN
    win_vld_p0  = pix_valid;
    if (row_p0 == '0) begin
      win_data_p0 = {pix_in, pix_in, pix_in};
    end else if (row_p0 == RW'(1)) begin
      win_data_p0 = {rd1_p0, rd1_p0, pix_in};
    end
`else
    win_vld_p0  = pix_valid && (row_p0 >= RW'(2));
`endif
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_valid) begin
      if (end_col_p0) begin
        col_cnt <= '0;
        row_cnt <= end_row_p0 ? '0 : row_p0 + RW'(1);
      end else begin
        col_cnt <= col_p0 + CW'(1);
        row_cnt <= row_p0;
      end
    end
  end

  // Line stores are never cleared; rows 0 and 1 of every frame rewrite them before use.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line2[col_p0] <= rd1_p0;
      line1[col_p0] <= pix_in;
    end
  end

  // Stage p1: registered window column and its flags
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= win_vld_p0;
      last_p1 <= win_vld_p0 && end_col_p0;
      done_p1 <= win_vld_p0 && end_col_p0 && end_row_p0;
      if (win_vld_p0) begin
        data_p1 <= win_data_p0;
      end
    end
  end

  assign col_data   = data_p1;
  assign col_valid  = vld_p1;
  assign col_last   = last_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen on a 4x4 image of 8-bit pixels, value = 16*row + col.
module tb_line_window_gen;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef LWG_BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic [PW-1:0]   pix_in = '0;
  logic            pix_valid = 1'b0;
  logic            sof = 1'b0;
  logic [3*PW-1:0] col_data;
  logic            col_valid;
  logic            col_last;
  logic            frame_done;

  int checks = 0;
  int errors = 0;
  logic [3*PW-1:0] exp_data = '0;

  line_window_gen #(
    .PIXEL_WIDTH (PW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .col_data  (col_data),
    .col_valid (col_valid),
    .col_last  (col_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic ev, input logic el, input logic ed,
                       input logic [3*PW-1:0] edata);
    logic [3*PW+2:0] obs;
    logic [3*PW+2:0] expv;
    obs  = {col_valid, col_last, frame_done, col_data};
    expv = {ev, el, ed, edata};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed valid/last/done/data=%b/%b/%b/%h expected %b/%b/%b/%h",
             tag, col_valid, col_last, frame_done, col_data, ev, el, ed, edata);
    end
  endtask

  // One valid pixel at image position (r,c); expectations come from the image formula.
  task automatic pix_step(input int r, input int c, input logic s);
    logic [PW-1:0] p;
    logic ev;
    p = PW'(16 * r + c);
    pix_in = p;
    pix_valid = 1'b1;
    sof = s;
    @(posedge clk);
    #1;
    ev = BORDER || (r >= 2);
    if (ev) begin
      if (r >= 2)       exp_data = {PW'(16 * (r - 2) + c), PW'(16 * (r - 1) + c), p};
      else if (r == 1)  exp_data = {PW'(c), PW'(c), p};
      else              exp_data = {p, p, p};
    end
    check($sformatf("pix r%0d c%0d", r, c), ev, ev && (c == W - 1),
          ev && (c == W - 1) && (r == H - 1), exp_data);
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic gap_step(input logic s);
    pix_valid = 1'b0;
    sof = s;
    pix_in = 8'hEE;
    @(posedge clk);
    #1;
    check($sformatf("gap sof=%0b", s), 1'b0, 1'b0, 1'b0, exp_data);
    sof = 1'b0;
  endtask

  task automatic run_frame(input logic first_sof, input logic gapped);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        pix_step(r, c, first_sof && (r == 0) && (c == 0));
        if (gapped) gap_step((r == 1) && (c == 2));
      end
    end
  endtask

  initial begin
    #12;
    check("reset state", 1'b0, 1'b0, 1'b0, '0);
    arstn = 1'b1;

    // sof without pix_valid must not disturb anything
    gap_step(1'b1);

    // continuous frame, then a back-to-back frame relying on counter wrap
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);

    // gapped stream with a stray sof during one gap
    run_frame(1'b1, 1'b1);

    // sof arriving at pixel (2,1) abandons the partial frame
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) pix_step(r, c, (r == 0) && (c == 0));
    pix_step(2, 0, 1'b0);
    run_frame(1'b1, 1'b0);

    // reset pulse after pixel (2,2); next pixel is (0,0) without sof
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) pix_step(r, c, (r == 0) && (c == 0));
    for (int c = 0; c < 3; c++) pix_step(2, c, 1'b0);
    #2;
    arstn = 1'b0;
    #1;
    exp_data = '0;
    check("async reset mid-frame", 1'b0, 1'b0, 1'b0, '0);
    #2;
    arstn = 1'b1;
    run_frame(1'b0, 1'b0);
    gap_step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 14, meaning bits per pixel.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 128, meaning pixels per line.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 128, meaning lines per frame.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port arstn, input, 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have port pix_in, input, PIXEL_WIDTH, meaning a raster-order pixel.
REQ-007 SHALL have port pix_valid, input, 1, meaning pix_in is valid this cycle; there is no backpressure.
REQ-008 SHALL have port sof, input, 1, meaning the qualifying pixel is column 0, row 0 of a new frame.
REQ-009 SHALL have port col_data, output, 3*PIXEL_WIDTH, meaning the packed 3-line column: [PW-1:0] current row, [2PW-1:PW] row-1, [3PW-1:2PW] row-2.
REQ-010 SHALL have port col_valid, output, 1, meaning col_data is valid; it is directly compatible with the 3x3 averager din_valid.
REQ-011 SHALL have port col_last, output, 1, meaning col_data is the last column of its line.
REQ-012 SHALL have port frame_done, output, 1, meaning a one-cycle pulse with the last column of row IMAGE_HEIGHT-1.

Function
REQ-013 SHALL hold two line stores of IMAGE_WIDTH x PIXEL_WIDTH each: line1 holds row-1 and line2 holds row-2.
REQ-014 SHALL, on pix_valid at column c, read line1[c] and line2[c], write line2[c] <= old line1[c], and write line1[c] <= pix_in in the same cycle.
REQ-015 SHALL register col_data <= {line2[c], line1[c], pix_in}, giving a latency of exactly 1 cycle from pix_valid to col_valid.
REQ-016 SHALL keep the column counter col_cnt in 0..IMAGE_WIDTH-1; it advances only on pix_valid and wraps to 0 after IMAGE_WIDTH-1, which also increments row_cnt.
REQ-017 SHALL keep the row counter row_cnt in 0..IMAGE_HEIGHT-1; it wraps to 0 after the last column of row IMAGE_HEIGHT-1, which implicitly starts a new frame.
REQ-018 SHALL, when sof and pix_valid are both high, treat the pixel as column 0, row 0, with counters forced regardless of their current value.
REQ-019 SHALL ignore sof without pix_valid.
REQ-020 SHALL, when pix_valid is low, leave the counters and line stores unchanged and deassert col_valid, col_last and frame_done the next cycle.
REQ-021 SHALL hold col_data at its last value while col_valid is low.
REQ-022 SHALL register col_last with col_valid when col_cnt==IMAGE_WIDTH-1.
REQ-023 SHALL register frame_done with col_valid when col_cnt==IMAGE_WIDTH-1 and row_cnt==IMAGE_HEIGHT-1.
REQ-024 SHALL, when sof arrives mid-frame, abandon the partial frame, emit no frame_done for it, and gate validity from the new row 0.
REQ-025 SHALL require IMAGE_WIDTH>=2 and IMAGE_HEIGHT>=3.

Reset
REQ-026 SHALL, on arstn low, asynchronously clear col_cnt, row_cnt, col_data, col_valid, col_last and frame_done to 0.
REQ-027 SHALL NOT reset the line-store contents; stale data is never marked valid after reset.
REQ-028 SHALL, on reset mid-frame, treat the next pixel as column 0, row 0 whether or not sof is present.

Configuration
REQ-029 SHALL, with macro LWG_BORDER_REPLICATE_EN defined, assert col_valid for every pixel of rows 0 and 1; row 0 outputs {pix,pix,pix}, and row 1 outputs {line1[c],line1[c],pix}.
REQ-030 SHALL, without LWG_BORDER_REPLICATE_EN, assert col_valid only for rows 2..IMAGE_HEIGHT-1, so col_last and frame_done never fire in rows 0 and 1.

Verification (PIXEL_WIDTH=8, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, pixel value = 16*row+col)
REQ-031 SHALL cover a continuous frame with macro off: valid high throughout, sof on the first pixel -> 8 col_valid cycles; the first is col_data={0x00,0x10,0x20} one cycle after pixel (2,0); col_last on columns 3 and 7; frame_done with the 8th.
REQ-032 SHALL cover a gapped stream: pix_valid toggling 1,0,1,0 -> identical col_data sequence to REQ-031, with col_valid low in the cycle after each gap.
REQ-033 SHALL cover a mid-frame sof: sof at pixel (2,1) -> no frame_done for the aborted frame, and no col_valid until row 2 of the new frame.
REQ-034 SHALL cover reset mid-operation: arstn pulsed low after pixel (2,2) -> outputs 0 immediately, and the next pixel is taken as (0,0) with no col_valid for two rows.
REQ-035 SHALL cover the macro on: pixel (0,1) -> col_data={0x01,0x01,0x01} valid; pixel (1,1) -> {0x01,0x01,0x11}.
REQ-036 SHALL cover back-to-back frames without a gap -> frame_done on the last column of each frame, and the second frame's data equals the first's.
